// File: rtl/booth_mul_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, the recoded
// Booth digit, and the accumulator width helper.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // One radix-4 Booth digit in sign/magnitude form: value is 0, +-M or +-2M.
    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_digit_t;

    // Guard bits above the operand width so that A +- 2M never wraps.
    localparam int ACC_GUARD = 4;

    function automatic int acc_width(input int width);
        return width + ACC_GUARD;
    endfunction

endpackage

// File: rtl/booth_mul_r4_if.sv
// Start/busy/done handshake bundle between a datapath controller (master)
// and the multiplier (slave).
interface booth_mul_r4_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, multiplier, multiplicand,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, multiplier, multiplicand,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_r4_enc.sv
// Combinational radix-4 Booth recoder: {Q[1],Q[0],Q_1} -> {zero, two, neg}.
// Kept standalone so an array multiplier can reuse it per partial product.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]   trip,
    output booth_digit_t dig
);

    // Map the overlapping bit triplet onto digit magnitude and sign.
    always_comb begin
        dig = '{zero: 1'b0, two: 1'b0, neg: 1'b0};
        case (trip)
            3'b000, 3'b111: dig.zero = 1'b1;
            3'b001, 3'b010: dig.neg  = 1'b0;
            3'b011:         dig.two  = 1'b1;
            3'b100:         begin dig.two = 1'b1; dig.neg = 1'b1; end
            3'b101, 3'b110: dig.neg  = 1'b1;
            default:        dig.zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier. Retires two multiplier bits per clock,
// signed or unsigned per operation, start/busy/done handshake.
module booth_mul_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    booth_mul_r4_if.slave  bus
);

    localparam int ITER  = WIDTH / 2 + 1;
    localparam int AW    = acc_width(WIDTH);
    localparam int QW    = WIDTH + 2;
    localparam int CNT_W = $clog2(ITER);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_mul_r4: WIDTH must be even and >= 4");
    end

    state_t                  state;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    m_reg;
    logic        [QW-1:0]    q_reg;
    logic                    q_1;
    logic        [CNT_W-1:0] cnt;
    logic                    done_r;
    logic [2*WIDTH-1:0]      prod_r;

    booth_digit_t            dig;
    logic signed [AW-1:0]    mag;
    logic signed [AW-1:0]    addend;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    nxt_acc;
    logic        [QW-1:0]    nxt_q;
    logic [2*WIDTH-1:0]      nxt_prod;

    // Two extra multiplier bits make the unsigned case a positive signed
    // number with an even bit count, so ITER digits cover it exactly.
    function automatic logic [QW-1:0] ext_q(input logic [WIDTH-1:0] x, input logic sgn);
        return {{2{sgn & x[WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [AW-1:0] ext_m(input logic [WIDTH-1:0] x, input logic sgn);
        return {{(AW-WIDTH){sgn & x[WIDTH-1]}}, x};
    endfunction

    booth_r4_enc u_enc (
        .trip ({q_reg[1:0], q_1}),
        .dig  (dig)
    );

    // Add the selected multiple of M, then arithmetic-shift {A,Q,Q_1} by two.
    always_comb begin
        mag      = dig.two ? (m_reg <<< 1) : m_reg;
        addend   = dig.zero ? '0 : (dig.neg ? -mag : mag);
        sum      = acc + addend;
        nxt_acc  = sum >>> 2;
        nxt_q    = {sum[1:0], q_reg[QW-1:2]};
        nxt_prod = {nxt_acc[WIDTH-3:0], nxt_q};
    end

    // Control FSM, iteration counter, shift register and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        q_reg <= ext_q(bus.multiplier, bus.is_signed);
                        q_1   <= 1'b0;
                        m_reg <= ext_m(bus.multiplicand, bus.is_signed);
                        cnt   <= CNT_W'(ITER - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= nxt_acc;
                    q_reg <= nxt_q;
                    q_1   <= q_reg[1];
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                        prod_r <= nxt_prod;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == CALC);
    assign bus.done    = done_r;
    assign bus.product = prod_r;

endmodule
